exp2_pipe: RTL and testbench

- Pipelined fixed-point antilog (2^x) unit. It is the inverse companion of the integer-log2 pipeline in the chaining datapath.
- Converts a Q5.3 log-domain value back to a linear integer. Used to rebuild gap and span magnitudes from log-compressed scores.
- Streaming valid/ready interface with full backpressure; 3-stage pipeline; one result per cycle when not stalled.

---
 rtl/exp2_pipe.sv | 78 +++++++
 tb/tb_exp2_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/exp2_pipe.sv
// Pipelined Q5.3 antilog: out_data = floor(2^(e + f/8)), saturated to OUT_W bits.
// Three register stages (mantissa lookup, shift, truncate/saturate) under one global stall.
module exp2_pipe #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_log,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    // round(128 * 2^(f/8)) in Q1.7
    localparam logic [7:0] MANT_LUT [8] = '{8'd128, 8'd140, 8'd152, 8'd166,
                                            8'd181, 8'd197, 8'd215, 8'd235};
    localparam logic [32:0] MAX_OUT = (33'd1 << OUT_W) - 33'd1;

    logic             adv;
    logic             s1_valid_reg;
    logic             s1_zero_reg;
    logic [4:0]       s1_exp_reg;
    logic [7:0]       s1_mant_reg;
    logic             s2_valid_reg;
    logic             s2_zero_reg;
    logic [38:0]      s2_prod_reg;
    logic             out_valid_reg;
    logic [OUT_W-1:0] out_data_reg;
    logic [31:0]      shifted;
    logic [OUT_W-1:0] out_data_next;

    // Stall is driven only by the output register, so in_ready never depends on in_valid.
    assign adv       = !out_valid_reg || out_ready;
    assign in_ready  = adv && !reset;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    assign shifted = s2_prod_reg[38:7];

    always_comb begin
        out_data_next = '0;
        if (s2_zero_reg) begin
            out_data_next = '0;
        end else if ({1'b0, shifted} > MAX_OUT) begin
            out_data_next = '1;
        end else begin
            out_data_next = shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_zero_reg   <= 1'b0;
            s1_exp_reg    <= '0;
            s1_mant_reg   <= '0;
            s2_valid_reg  <= 1'b0;
            s2_zero_reg   <= 1'b0;
            s2_prod_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (adv) begin
            s1_valid_reg  <= in_valid;
            s1_zero_reg   <= in_zero;
            s1_exp_reg    <= in_log[7:3];
            s1_mant_reg   <= MANT_LUT[in_log[2:0]];
            s2_valid_reg  <= s1_valid_reg;
            s2_zero_reg   <= s1_zero_reg;
            s2_prod_reg   <= {31'd0, s1_mant_reg} << s1_exp_reg;
            out_valid_reg <= s2_valid_reg;
            out_data_reg  <= out_data_next;
        end
    end

endmodule

// File: tb/tb_exp2_pipe.sv
// Randomized and directed bench for exp2_pipe; checks OUT_W=32 and OUT_W=16 copies
// against a real-arithmetic antilog model with a scoreboard of in-flight beats.
module tb_exp2_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_log;
    logic        in_zero;
    logic        out_ready;
    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic        in_ready_b, out_valid_b;
    logic [15:0] out_data_b;

    always #5 clk = ~clk;

    exp2_pipe #(.OUT_W(32)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_log(in_log), .in_zero(in_zero), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a)
    );

    exp2_pipe #(.OUT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_log(in_log), .in_zero(in_zero), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b)
    );

    typedef struct {
        logic [7:0] lg;
        logic       z;
        int         acc_cyc;
    } beat_t;

    typedef struct {
        logic [7:0] lg;
        logic       z;
    } stim_t;

    beat_t       exp_q[$];
    stim_t       stim_q[$];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          vprob = 100;
    int          rprob = 100;
    int          stall_left = 0;
    bit          arm_stall = 0;
    bit          free_run = 0;
    bit          prev_hold = 0;
    bit          prev_rst = 0;
    logic [31:0] prev_a;
    logic [15:0] prev_b;

    // floor(2^(e+f/8)) with the mantissa rounded to 7 fraction bits, then saturated
    function automatic logic [63:0] model(logic [7:0] lg, logic z, int w);
        int     e = int'(lg[7:3]);
        int     f = int'(lg[2:0]);
        longint m;
        longint r;
        longint mx;
        if (z) return 64'd0;
        m  = longint'($rtoi(128.0 * (2.0 ** (real'(f) / 8.0)) + 0.5));
        r  = (m << e) >>> 7;
        mx = (64'sd1 << w) - 1;
        return (r > mx) ? mx : r;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic monitor();
        beat_t b;
        if (prev_rst) begin
            check("rst_out_valid", out_valid_a, 0);
            check("rst_out_data", out_data_a, 0);
            check("rst_out_data16", out_data_b, 0);
        end
        if (reset) begin
            check("rst_in_ready", in_ready_a, 0);
            exp_q.delete();
        end else begin
            check("in_ready_rule", in_ready_a, !out_valid_a || out_ready);
            check("in_ready_rule16", in_ready_b, !out_valid_a || out_ready);
            if (free_run) check("in_ready_free", in_ready_a, 1);
            if (prev_hold) begin
                check("hold_valid", out_valid_a, 1);
                check("hold_data", out_data_a, prev_a);
                check("hold_data16", out_data_b, prev_b);
            end
            check("occupancy", exp_q.size() <= 3, 1);
            if (out_valid_a) check("spurious_valid", exp_q.size() > 0, 1);
            if (out_valid_a && out_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check("data32", out_data_a, model(b.lg, b.z, 32));
                check("data16", out_data_b, model(b.lg, b.z, 16));
                check("valid16", out_valid_b, 1);
                if (free_run) check("latency", cyc - b.acc_cyc, 3);
                $display("beat log=%02h zero=%0d -> %08h / %04h", b.lg, b.z, out_data_a, out_data_b);
                if (arm_stall) begin
                    arm_stall  = 0;
                    stall_left = 6;
                end
            end
            if (in_valid && in_ready_a) begin
                exp_q.push_back('{lg: in_log, z: in_zero, acc_cyc: cyc});
                void'(stim_q.pop_front());
            end
        end
        prev_hold = !reset && out_valid_a && !out_ready;
        prev_a    = out_data_a;
        prev_b    = out_data_b;
        prev_rst  = reset;
        if (stall_left > 0) stall_left--;
    endtask

    task automatic step(logic rst);
        @(negedge clk);
        cyc++;
        reset = rst;
        if (stim_q.size() > 0 && $urandom_range(99) < vprob) begin
            in_valid = 1'b1;
            in_log   = stim_q[0].lg;
            in_zero  = stim_q[0].z;
        end else begin
            in_valid = 1'b0;
            in_log   = 8'($urandom);
            in_zero  = 1'($urandom);
        end
        out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(99) < rprob);
        #1;
        monitor();
    endtask

    task automatic drain(int max_cycles);
        int n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
            step(1'b0);
            n++;
        end
        if (n >= max_cycles) check("drain_timeout", 0, 1);
    endtask

    task automatic add(logic [7:0] lg, logic z);
        stim_q.push_back('{lg: lg, z: z});
    endtask

    initial begin
        logic [7:0] singles [9];
        logic       zeros [9];
        singles = '{8'h00, 8'h08, 8'h0C, 8'h54, 8'hA3, 8'hFF, 8'hFF, 8'h08, 8'h78};
        zeros   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        reset = 1'b1; in_valid = 1'b0; in_log = '0; in_zero = 1'b0; out_ready = 1'b1;
        step(1'b1);
        step(1'b1);

        // Isolated beats at full readiness, including zero override and 16-bit saturation points
        free_run = 1;
        for (int i = 0; i < 9; i++) begin
            add(singles[i], zeros[i]);
            drain(20);
            repeat (2) step(1'b0);
        end
        add(8'h7F, 1'b0); drain(20);
        add(8'h80, 1'b0); drain(20);

        // Back-to-back stream
        for (int i = 0; i < 40; i++) add(8'(i), 1'b0);
        drain(100);

        // Backpressure: five stalled cycles right after the first result
        free_run = 0;
        for (int i = 0; i < 10; i++) add(8'($urandom), 1'b0);
        arm_stall = 1;
        drain(100);

        // Reset with three beats in flight, then a fresh beat
        free_run = 1;
        for (int i = 0; i < 3; i++) add(8'hF0 + 8'(i), 1'b0);
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (5) step(1'b0);
        add(8'h10, 1'b0);
        drain(20);

        // Randomized traffic with random backpressure
        free_run = 0;
        vprob = 70;
        rprob = 60;
        for (int i = 0; i < 300; i++) add(8'($urandom), ($urandom_range(9) == 0));
        drain(5000);
        repeat (4) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
